// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//   Bridges the hps_io ioctl download stream to an arcade core's ROM-load
//   port. Download writes are buffered in a small FIFO and forwarded under a
//   valid/ready handshake. The block also accumulates a byte count and a
//   16-bit checksum, and owns the core reset. It keeps the core in reset
//   through boot and download, and releases it only after a good download
//   plus a hold interval. User reset requests restart that interval.
//
// Ports
//   clk_sys        system clock, rising edge
//   reset          asynchronous active-high reset, clears all state
//   ioctl_download download-active level from hps_io
//   ioctl_wr       one-cycle download write strobe
//   ioctl_addr     download byte address, low ADDR_W bits used
//   ioctl_dout     download byte
//   user_rst       user reset request level
//   dn_wr          write valid towards the core (FIFO not empty)
//   dn_ready       core accepts the presented write
//   dn_addr        address of the presented write
//   dn_data        data of the presented write
//   core_reset     registered reset to the core
//   load_ok        last download complete and long enough
//   load_err       last download short or overflowed (sticky until next load)
//   byte_cnt       bytes accepted in the current/last download, saturating
//   checksum       mod-2^16 sum of accepted bytes
module rom_load_sequencer #(
  parameter int          ADDR_W     = 17,
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned EXP_BYTES  = 32'h10000,
  parameter int          RST_HOLD   = 1024
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              user_rst,
  output logic              dn_wr,
  input  logic              dn_ready,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              core_reset,
  output logic              load_ok,
  output logic              load_err,
  output logic [ADDR_W:0]   byte_cnt,
  output logic [15:0]       checksum
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int ENT_W  = ADDR_W + 8;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_FAIL  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              dl_q;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W:0]   byte_cnt_q, byte_cnt_d;
  logic [15:0]       checksum_q, checksum_d;
  logic              load_ok_q, load_ok_d;
  logic              load_err_q, load_err_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              core_reset_q, core_reset_d;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];

  logic             dl_rise, empty, full, pop, push_req, push, ovf;
  logic [ENT_W-1:0] head;

  // Upper download address bits are not forwarded.
  generate
    if (ADDR_W < 25) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^ioctl_addr[24:ADDR_W];
    end
  endgenerate

  // dl_q resets to 0, so a download already active at reset release is a rise.
  assign dl_rise  = ioctl_download & ~dl_q;
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_FULL);
  assign pop      = ~empty & dn_ready;
  // Writes are only taken while loading; DRAIN and every other state ignore them.
  assign push_req = ioctl_wr & ioctl_download & (state_q == S_LOAD);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push     = push_req & (~full | pop);
  assign ovf      = push_req & full & ~pop;

  assign head    = mem_q[rd_q];
  assign dn_wr   = ~empty;
  assign dn_addr = empty ? '0 : head[ENT_W-1:8];
  assign dn_data = empty ? '0 : head[7:0];

  assign core_reset = core_reset_q;
  assign load_ok    = load_ok_q;
  assign load_err   = load_err_q;
  assign byte_cnt   = byte_cnt_q;
  assign checksum   = checksum_q;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    checksum_d = checksum_q;
    load_ok_d  = load_ok_q;
    load_err_d = load_err_q;

    if (push) begin
      wr_d       = wr_q + PTR_W'(1);
      checksum_d = checksum_q + 16'(ioctl_dout);
      if (byte_cnt_q != '1) begin
        byte_cnt_d = byte_cnt_q + (ADDR_W + 1)'(1);
      end
    end
    if (pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (ovf) begin
      load_err_d = 1'b1;
    end

    case (state_q)
      S_BOOT: begin
      end
      S_LOAD: begin
        if (!ioctl_download) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // load_err can only be set by overflow at this point.
        if (empty) begin
          if ((32'(byte_cnt_q) >= EXP_BYTES) && !load_err_q) begin
            load_ok_d = 1'b1;
            hold_d    = '0;
            state_d   = S_HOLD;
          end else begin
            load_err_d = 1'b1;
            state_d    = S_FAIL;
          end
        end
      end
      S_HOLD: begin
        if (user_rst) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (user_rst) begin
          hold_d  = '0;
          state_d = S_HOLD;
        end
      end
      S_FAIL: begin
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase

    // A new download wins over everything: flush the FIFO and restart stats.
    if (dl_rise) begin
      state_d    = S_LOAD;
      hold_d     = '0;
      wr_d       = '0;
      rd_d       = '0;
      cnt_d      = '0;
      byte_cnt_d = '0;
      checksum_d = '0;
      load_ok_d  = 1'b0;
      load_err_d = 1'b0;
    end
  end

  // Registered from the next state so it drops exactly as RUN is entered.
  assign core_reset_d = (state_d != S_RUN);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_BOOT;
      dl_q         <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      byte_cnt_q   <= '0;
      checksum_q   <= '0;
      load_ok_q    <= 1'b0;
      load_err_q   <= 1'b0;
      hold_q       <= '0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      dl_q         <= ioctl_download;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      checksum_q   <= checksum_d;
      load_ok_q    <= load_ok_d;
      load_err_q   <= load_err_d;
      hold_q       <= hold_d;
      core_reset_q <= core_reset_d;
    end
  end

  // Storage only; outputs are masked while empty so no reset is needed here.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_q[wr_q] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout};
    end
  end

endmodule
